// File: rtl/nand_page_read_capture_if.sv
// Handshake/bus bundle for nand_page_read_capture.
// master = requester/host side, slave = the capture block.
// Optional checksum signals exist only when NAND_READ_CHECKSUM_EN is defined.
interface nand_page_read_capture_if #(
    parameter int CNT_W = 12
);
    logic             start;
    logic [CNT_W-1:0] byte_count;
    logic             abort;
    logic             nand_rb_n;
    logic [7:0]       nand_io_in;
    logic             nand_ce_n;
    logic             nand_re_n;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             err_timeout;
`ifdef NAND_READ_CHECKSUM_EN
    logic [15:0]      checksum;
    logic [7:0]       checksum_xor;

    modport master (
        output start, byte_count, abort, nand_rb_n, nand_io_in, out_ready,
        input  nand_ce_n, nand_re_n, out_data, out_valid, busy, done, err_timeout,
               checksum, checksum_xor
    );
    modport slave (
        input  start, byte_count, abort, nand_rb_n, nand_io_in, out_ready,
        output nand_ce_n, nand_re_n, out_data, out_valid, busy, done, err_timeout,
               checksum, checksum_xor
    );
`else
    modport master (
        output start, byte_count, abort, nand_rb_n, nand_io_in, out_ready,
        input  nand_ce_n, nand_re_n, out_data, out_valid, busy, done, err_timeout
    );
    modport slave (
        input  start, byte_count, abort, nand_rb_n, nand_io_in, out_ready,
        output nand_ce_n, nand_re_n, out_data, out_valid, busy, done, err_timeout
    );
`endif
endinterface

// File: rtl/nand_page_read_capture.sv
// NAND page read data capture: waits out tR on R/B#, strobes RE# per byte,
// captures IOX into a first-word-fall-through FIFO and streams it out on
// valid/ready. Optional macro NAND_READ_CHECKSUM_EN adds a running 16-bit
// sum and 8-bit XOR of the bytes captured in the current transfer.
module nand_page_read_capture #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 12,
    parameter int RE_LOW_CYC  = 2,
    parameter int RE_HIGH_CYC = 2,
    parameter int TWB_CYC     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic                   clk,
    input logic                   rst,
    nand_page_read_capture_if.slave bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int MAX_A   = (TIMEOUT_CYC > TWB_CYC) ? TIMEOUT_CYC : TWB_CYC;
    localparam int MAX_B   = (RE_LOW_CYC > RE_HIGH_CYC) ? RE_LOW_CYC : RE_HIGH_CYC;
    localparam int TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TWB_LAST  = TMR_W'(TWB_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] LOW_LAST  = TMR_W'(RE_LOW_CYC - 1);
    localparam logic [TMR_W-1:0] HIGH_LAST = TMR_W'(RE_HIGH_CYC - 1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_READY,
        S_RE_LOW,
        S_RE_HIGH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [CNT_W-1:0] remaining;
    logic             rb_meta, rb_sync;
    logic             accept, push, pop;
    logic             busy_nxt;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_space;
    logic             out_valid_w;

    logic             ce_n_q, re_n_q, busy_q, done_q, err_q;

    assign fifo_space  = (count != DEPTH_C);
    assign out_valid_w = (count != '0);
    assign pop         = out_valid_w & bus.out_ready;

    assign bus.out_valid   = out_valid_w;
    assign bus.out_data    = mem[rd_ptr];
    assign bus.nand_ce_n   = ce_n_q;
    assign bus.nand_re_n   = re_n_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;

    // Two-flop synchroniser for the asynchronous R/B# pin; idles "ready".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rb_meta <= 1'b1;
            rb_sync <= 1'b1;
        end else begin
            rb_meta <= bus.nand_rb_n;
            rb_sync <= rb_meta;
        end
    end

    // State and phase-timer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Next-state logic; one shared timer measures every timed phase.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr + TMR_W'(1);
        accept    = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                tmr_nxt = '0;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = (bus.byte_count == '0) ? S_DONE : S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // The device may have gone busy and back before we notice; cap the wait.
                if (!rb_sync || tmr == TWB_LAST) begin
                    state_nxt = S_WAIT_READY;
                    tmr_nxt   = '0;
                end
            end
            S_WAIT_READY: begin
                if (rb_sync) begin
                    tmr_nxt = '0;
                    if (fifo_space) state_nxt = S_RE_LOW;
                end else if (tmr == TMO_LAST) begin
                    state_nxt = S_ERROR;
                end
            end
            S_RE_LOW: begin
                // Sample on the edge that ends the low phase, while RE# is still low.
                if (tmr == LOW_LAST) begin
                    push      = 1'b1;
                    state_nxt = S_RE_HIGH;
                    tmr_nxt   = '0;
                end
            end
            S_RE_HIGH: begin
                // Timer parks at the last count while stalled on a full FIFO.
                if (tmr >= HIGH_LAST) begin
                    tmr_nxt = tmr;
                    if (remaining == '0) begin
                        state_nxt = S_DONE;
                        tmr_nxt   = '0;
                    end else if (fifo_space) begin
                        state_nxt = S_RE_LOW;
                        tmr_nxt   = '0;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                state_nxt = S_IDLE;
                tmr_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                tmr_nxt   = '0;
            end
        endcase
        if (bus.abort) begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
            accept    = 1'b0;
            push      = 1'b0;
        end
    end

    assign busy_nxt = (state_nxt == S_WAIT_BUSY) || (state_nxt == S_WAIT_READY) ||
                      (state_nxt == S_RE_LOW)    || (state_nxt == S_RE_HIGH);

    // Pin and status outputs registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_n_q <= 1'b1;
            re_n_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ce_n_q <= ~busy_nxt;
            re_n_q <= (state_nxt != S_RE_LOW);
            busy_q <= busy_nxt;
            done_q <= (state_nxt == S_DONE);
            if (accept)                    err_q <= 1'b0;
            else if (state_nxt == S_ERROR) err_q <= 1'b1;
        end
    end

    // Bytes still to be strobed out of the device.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        remaining <= '0;
        else if (accept) remaining <= bus.byte_count;
        else if (push)   remaining <= remaining - CNT_W'(1);
    end

    // Capture FIFO; abort flushes it, data array keeps stale bytes behind out_valid=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (bus.abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.nand_io_in;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef NAND_READ_CHECKSUM_EN
    logic [15:0] sum_q;
    logic [7:0]  xor_q;

    assign bus.checksum     = sum_q;
    assign bus.checksum_xor = xor_q;

    // Running sum/XOR of bytes captured since the last accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            xor_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
            xor_q <= '0;
        end else if (push) begin
            sum_q <= sum_q + {8'h00, bus.nand_io_in};
            xor_q <= xor_q ^ bus.nand_io_in;
        end
    end
`endif

endmodule
